// File: rtl/speed_ctrl_pkg.sv
// Shared state type, register bit positions and divider mask helper
// for the CPU speed-mode controller.
package speed_ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } speed_state_t;

    localparam int unsigned RD_BUSY     = 7;
    localparam int unsigned RD_MODE_LSB = 4;
    localparam int unsigned RD_TGT_LSB  = 1;
    localparam int unsigned RD_ARM      = 0;

    // Divider mask for a mode: the fastest mode gets an all-zero mask.
    function automatic logic [7:0] mode_mask(input int unsigned mode,
                                             input int unsigned num_modes);
        logic [8:0] w_one;
        w_one = 9'(1) << (num_modes - 1 - mode);
        return 8'(w_one - 9'd1);
    endfunction

endpackage

// File: rtl/cpu_enable_divider.sv
// Free-running divider producing the CPU clock enable for the current mode;
// held at zero while a speed switch is settling.
module cpu_enable_divider
    import speed_ctrl_pkg::*;
#(
    parameter int unsigned NUM_MODES = 2,
    parameter int unsigned MODE_W    = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [MODE_W-1:0] mode,
    input  logic              hold,
    output logic              en
);

    localparam int unsigned DIV_W = (NUM_MODES > 2) ? NUM_MODES - 1 : 1;

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_mask;

    assign w_mask = DIV_W'(mode_mask(32'(mode), NUM_MODES));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if (hold) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    assign en = ~hold & ((r_div & w_mask) == '0);

endmodule

// File: rtl/speed_controller.sv
// CPU speed-mode controller: register-armed mode change committed on STOP,
// followed by a fixed settle freeze and a one-cycle wake pulse.
module speed_controller
    import speed_ctrl_pkg::*;
#(
    parameter  int unsigned NUM_MODES     = 2,
    parameter  int unsigned SETTLE_CYCLES = 8200,
    parameter  int unsigned RESET_MODE    = 0,
    localparam int unsigned MODE_W        = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cgb,
    input  logic              stop,
    input  logic [7:0]        wdata,
    input  logic              write,
    output logic [7:0]        rdata,
    output logic              cpu_en,
    output logic [MODE_W-1:0] mode,
    output logic              switching,
    output logic              wake
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    speed_state_t      r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [MODE_W-1:0] r_mode;
    logic [MODE_W-1:0] r_target;
    logic              r_armed;
    logic              r_wake;
    logic              r_stop_q;

    speed_state_t      w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [MODE_W-1:0] w_mode_nxt;
    logic [MODE_W-1:0] w_target_nxt;
    logic              w_armed_nxt;
    logic              w_wake_nxt;

    logic              w_en;
    logic              w_hold;
    logic              w_stop_rise;
    logic              w_wr_valid;
    logic              w_unused_wdata;

    assign w_hold         = (r_state == SETTLE);
    assign w_stop_rise    = stop & ~r_stop_q;
    assign w_wr_valid     = (32'(wdata[3:1]) < NUM_MODES);
    assign w_unused_wdata = ^wdata[7:4];

    cpu_enable_divider #(
        .NUM_MODES (NUM_MODES),
        .MODE_W    (MODE_W)
    ) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .mode    (r_mode),
        .hold    (w_hold),
        .en      (w_en)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stop_q <= 1'b0;
        end else begin
            r_stop_q <= stop;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_mode   <= MODE_W'(RESET_MODE);
            r_target <= '0;
            r_armed  <= 1'b0;
            r_wake   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_mode   <= w_mode_nxt;
            r_target <= w_target_nxt;
            r_armed  <= w_armed_nxt;
            r_wake   <= w_wake_nxt;
        end
    end

    // STOP edge outranks a same-cycle register write; SETTLE ignores both.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_mode_nxt   = r_mode;
        w_target_nxt = r_target;
        w_armed_nxt  = r_armed;
        w_wake_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_stop_rise) begin
                    if (r_armed && cgb && (r_target != r_mode)) begin
                        w_state_nxt = SETTLE;
                        w_cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
                    end else begin
                        w_armed_nxt = 1'b0;
                    end
                end else if (write && w_en && w_wr_valid) begin
                    w_target_nxt = MODE_W'(wdata[3:1]);
                    w_armed_nxt  = wdata[0];
                end
            end
            SETTLE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_mode_nxt  = r_target;
                    w_armed_nxt = 1'b0;
                    w_wake_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        rdata                   = '0;
        rdata[RD_BUSY]          = w_hold;
        rdata[RD_MODE_LSB +: 3] = 3'(r_mode);
        rdata[RD_TGT_LSB +: 3]  = 3'(r_target);
        rdata[RD_ARM]           = r_armed;
    end

    assign cpu_en    = w_en;
    assign mode      = r_mode;
    assign switching = w_hold;
    assign wake      = r_wake;

endmodule

// File: tb/tb_speed_controller.sv
// Bench for speed_controller: two configurations share one stimulus stream and
// are compared every cycle against a cycle-count reference model.
module tb_speed_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cgb;
    logic       stop;
    logic       write;
    logic [7:0] wdata;

    logic [7:0] rdata2, rdata4;
    logic       en2, en4;
    logic [0:0] mode2;
    logic [1:0] mode4;
    logic       sw2, sw4, wake2, wake4;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;
    int sw2_total = 0;
    int wake2_total = 0;

    always #5 clk = ~clk;

    speed_controller #(.NUM_MODES(2), .SETTLE_CYCLES(16), .RESET_MODE(0)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .cgb(cgb), .stop(stop), .wdata(wdata),
        .write(write), .rdata(rdata2), .cpu_en(en2), .mode(mode2),
        .switching(sw2), .wake(wake2)
    );

    speed_controller #(.NUM_MODES(4), .SETTLE_CYCLES(4), .RESET_MODE(0)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .cgb(cgb), .stop(stop), .wdata(wdata),
        .write(write), .rdata(rdata4), .cpu_en(en4), .mode(mode4),
        .switching(sw4), .wake(wake4)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0t actual=0x%0h required=0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: index 0 = 2 modes / 16 settle, index 1 = 4 modes / 4 settle.
    int m_mode[2];
    int m_tgt[2];
    int m_arm[2];
    int m_busy[2];
    int m_k[2];
    int m_wake[2];
    int m_stopq;
    bit m_rise;
    bit m_en;

    function automatic int nm(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic int sc(input int i);
        return (i == 0) ? 16 : 4;
    endfunction

    function automatic int exp_en(input int i);
        int period;
        period = 1 << (nm(i) - 1 - m_mode[i]);
        return (m_busy[i] == 0 && (m_k[i] % period) == 0) ? 1 : 0;
    endfunction

    function automatic int exp_rd(input int i);
        return ((m_busy[i] > 0) ? 128 : 0) + m_mode[i] * 16 + m_tgt[i] * 2 + m_arm[i];
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                m_mode[i] = 0; m_tgt[i] = 0; m_arm[i] = 0;
                m_busy[i] = 0; m_k[i] = 0;   m_wake[i] = 0;
            end
            m_stopq = 0;
        end else begin
            m_rise  = stop && (m_stopq == 0);
            m_stopq = int'(stop);
            for (int i = 0; i < 2; i++) begin
                m_en      = (exp_en(i) == 1);
                m_wake[i] = 0;
                if (m_busy[i] > 0) begin
                    m_busy[i]--;
                    m_k[i] = 0;
                    if (m_busy[i] == 0) begin
                        m_mode[i] = m_tgt[i];
                        m_arm[i]  = 0;
                        m_wake[i] = 1;
                    end
                end else begin
                    m_k[i]++;
                    if (m_rise) begin
                        if (m_arm[i] == 1 && cgb && m_tgt[i] != m_mode[i]) m_busy[i] = sc(i);
                        else m_arm[i] = 0;
                    end else if (write && m_en && int'(wdata[3:1]) < nm(i)) begin
                        m_tgt[i] = int'(wdata[3:1]);
                        m_arm[i] = int'(wdata[0]);
                    end
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    initial forever begin
        @(posedge clk);
        #1;
        if (run_cmp) begin
            check("dut2.mode",      int'(mode2),  m_mode[0]);
            check("dut2.rdata",     int'(rdata2), exp_rd(0));
            check("dut2.cpu_en",    int'(en2),    exp_en(0));
            check("dut2.switching", int'(sw2),    (m_busy[0] > 0) ? 1 : 0);
            check("dut2.wake",      int'(wake2),  m_wake[0]);
            check("dut4.mode",      int'(mode4),  m_mode[1]);
            check("dut4.rdata",     int'(rdata4), exp_rd(1));
            check("dut4.cpu_en",    int'(en4),    exp_en(1));
            check("dut4.switching", int'(sw4),    (m_busy[1] > 0) ? 1 : 0);
            check("dut4.wake",      int'(wake4),  m_wake[1]);
            if (sw2)   sw2_total++;
            if (wake2) wake2_total++;
        end
    end

    task automatic do_write(input logic [7:0] v);
        @(negedge clk);
        write = 1'b1;
        wdata = v;
        repeat (8) @(negedge clk);
        write = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        stop = 1'b1;
        repeat (2) @(negedge clk);
        stop = 1'b0;
        repeat (24) @(negedge clk);
    endtask

    task automatic count_en4(input string name, input int exp);
        int n;
        n = 0;
        repeat (16) begin
            @(posedge clk);
            #1;
            n += int'(en4);
        end
        check(name, n, exp);
        @(negedge clk);
    endtask

    initial begin
        int n_sw, n_bad, n_wake, n_en, sw_base, wake_base;
        reset_n = 1'b0; cgb = 1'b1; stop = 1'b0; write = 1'b0; wdata = 8'h00;
        run_cmp = 1'b1;
        repeat (3) @(negedge clk);

        // Reset release: enable alternates starting high in mode 0
        reset_n = 1'b1;
        #1;
        check("rst.rdata", int'(rdata2), 'h00);
        check("rst.mode",  int'(mode2),  0);
        check("rst.en0",   int'(en2),    1);
        @(posedge clk); #1; check("rst.en1", int'(en2), 0);
        @(posedge clk); #1; check("rst.en2", int'(en2), 1);
        @(posedge clk); #1; check("rst.en3", int'(en2), 0);

        // Arm and switch 0 -> 1
        do_write(8'h03);
        check("arm.rdata", int'(rdata2), 'h03);
        @(negedge clk);
        stop = 1'b1;
        n_sw = 0; n_bad = 0; n_wake = 0;
        repeat (24) begin
            @(posedge clk); #1;
            if (sw2) n_sw++;
            if (sw2 && en2) n_bad++;
            if (wake2) n_wake++;
        end
        check("switch.cycles", n_sw, 16);
        check("switch.en_low", n_bad, 0);
        check("switch.wake",   n_wake, 1);
        check("switch.rdata",  int'(rdata2), 'h12);
        check("switch.mode",   int'(mode2), 1);
        n_en = 0;
        repeat (4) begin @(posedge clk); #1; n_en += int'(en2); end
        check("switch.en_fast", n_en, 4);
        @(negedge clk);
        stop = 1'b0;

        // No-op STOPs: unarmed, and armed with target equal to mode
        sw_base = sw2_total;
        do_write(8'h02);
        check("noop.wr_unarmed", int'(rdata2), 'h12);
        pulse_stop();
        check("noop.stop_unarmed", int'(rdata2), 'h12);
        do_write(8'h03);
        check("noop.wr_same", int'(rdata2), 'h13);
        pulse_stop();
        check("noop.stop_same", int'(rdata2), 'h12);
        check("noop.no_settle", sw2_total - sw_base, 0);

        // Monochrome lock
        cgb = 1'b0;
        do_write(8'h01);
        check("dmg.wr", int'(rdata2), 'h11);
        pulse_stop();
        check("dmg.rdata", int'(rdata2), 'h10);
        check("dmg.mode", int'(mode2), 1);
        check("dmg.no_settle", sw2_total - sw_base, 0);
        cgb = 1'b1;

        // Write coincident with the STOP edge is discarded
        @(negedge clk);
        stop = 1'b1; write = 1'b1; wdata = 8'h03;
        @(negedge clk);
        write = 1'b0;
        repeat (2) @(negedge clk);
        stop = 1'b0;
        repeat (2) @(negedge clk);
        check("collide.rdata", int'(rdata2), 'h10);

        // Reset during settle cycle 8 aborts without a wake
        do_write(8'h01);
        check("abort.armed", int'(rdata2), 'h11);
        wake_base = wake2_total;
        @(negedge clk);
        stop = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("abort.in_settle", int'(sw2), 1);
        reset_n = 1'b0;
        #1;
        check("abort.sw",    int'(sw2),    0);
        check("abort.rdata", int'(rdata2), 'h00);
        check("abort.en",    int'(en2),    1);
        check("abort.wake",  int'(wake2),  0);
        repeat (3) @(negedge clk);
        stop = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort.no_wake", wake2_total - wake_base, 0);

        // Four-mode instance: enable period per mode, out-of-range target
        count_en4("m4.period_mode0", 2);
        do_write(8'h05);
        pulse_stop();
        check("m4.mode2", int'(mode4), 2);
        count_en4("m4.period_mode2", 8);
        do_write(8'h03);
        pulse_stop();
        check("m4.mode1", int'(mode4), 1);
        count_en4("m4.period_mode1", 4);
        do_write(8'h07);
        pulse_stop();
        check("m4.mode3", int'(mode4), 3);
        count_en4("m4.period_mode3", 16);
        check("m4.rdata3", int'(rdata4), 'h36);
        do_write(8'h0B);
        check("m4.bad_target", int'(rdata4), 'h36);

        // Randomized traffic
        repeat (3000) begin
            @(negedge clk);
            reset_n = ($urandom_range(0, 399) != 0);
            cgb     = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 5) == 0) stop = ~stop;
            write   = ($urandom_range(0, 3) == 0);
            wdata   = 8'($urandom);
        end
        @(negedge clk);
        reset_n = 1'b1; write = 1'b0;
        repeat (4) @(negedge clk);
        run_cmp = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
